axi_sram_burst_slave: RTL and testbench

- AXI4 slave responder that services INCR bursts issued by the DMA master engine and the CPU masters into a single-port word SRAM macro.
- Sits on a bridge slave port and terminates AR/R and AW/W/B channels.
- Drives the SRAM chip-select, byte-write-enable, address and data pins.
- Handles one transaction at a time, read or write; no outstanding or interleaved transactions.

---
 rtl/axi_sram_pkg.sv | 21 ++
 rtl/axi_sram_burst_slave.sv | 175 +++++++++++++++++
 tb/tb_axi_sram_burst_slave.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_pkg.sv
// rtl/axi_sram_pkg.sv - shared types and constants for the AXI burst SRAM slave
package axi_sram_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

endpackage

// File: rtl/axi_sram_burst_slave.sv
// rtl/axi_sram_burst_slave.sv - single-transaction AXI4 INCR burst slave onto a word SRAM
// Optional out-of-range beat suppression: AXI_SRAM_RANGE_CHECK_EN
module axi_sram_burst_slave
    import axi_sram_pkg::*;
#(
    parameter int ID_W    = 8,
    parameter int AW_WORD = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     arid,
    input  logic [31:0]         araddr,
    input  logic [3:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ID_W-1:0]     awid,
    input  logic [31:0]         awaddr,
    input  logic [3:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    output logic                sram_cs,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [AW_WORD-1:0]  sram_a,
    output logic [DATA_W-1:0]   sram_d,
    input  logic [DATA_W-1:0]   sram_q
);

    state_t               state;
    logic [ID_W-1:0]      id_q;
    logic [AW_WORD-1:0]   addr_q;
    logic [AW_WORD-1:0]   addr_next;
    logic [3:0]           len_q;
    logic [3:0]           cnt;
    logic [1:0]           burst_q;
    logic                 err_q;
    logic                 oor_q;
    logic                 rd_first;
    logic [DATA_W-1:0]    rdata_q;
    logic [DATA_W-1:0]    beat_q;
    logic                 last_beat;
    logic                 w_fire;
    logic                 ar_oor;
    logic                 aw_oor;
    logic                 unused_addr_bits;

`ifdef AXI_SRAM_RANGE_CHECK_EN
    assign ar_oor = |araddr[31:AW_WORD+2];
    assign aw_oor = |awaddr[31:AW_WORD+2];
`else
    assign ar_oor = 1'b0;
    assign aw_oor = 1'b0;
`endif

    assign unused_addr_bits = ^{araddr[31:AW_WORD+2], araddr[1:0],
                                awaddr[31:AW_WORD+2], awaddr[1:0]};

    assign last_beat = (cnt == len_q);
    assign w_fire    = (state == WR_DATA) && wvalid;
    assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + 1'b1;

    // Readies are gated by rst so nothing is offered while reset is held.
    assign awready = rst && (state == IDLE);
    assign arready = rst && (state == IDLE) && !awvalid;
    assign rvalid  = (state == RD_DATA);
    assign rlast   = rvalid && last_beat;
    assign rresp   = (rvalid && oor_q) ? RESP_SLVERR : RESP_OKAY;
    assign rid     = id_q;
    assign wready  = (state == WR_DATA);
    assign bvalid  = (state == WR_RESP);
    assign bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign bid     = id_q;

    // SRAM data is only valid in the first RD_DATA cycle; afterwards the held copy is shown.
    assign beat_q  = oor_q ? '0 : sram_q;
    assign rdata   = rd_first ? beat_q : rdata_q;

    assign sram_cs = ((state == RD_REQ) || w_fire) && !oor_q;
    assign sram_we = (w_fire && !oor_q) ? wstrb : '0;
    assign sram_a  = addr_q;
    assign sram_d  = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt      <= '0;
            burst_q  <= BURST_FIXED;
            err_q    <= 1'b0;
            oor_q    <= 1'b0;
            rd_first <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (awvalid) begin
                        id_q    <= awid;
                        addr_q  <= awaddr[AW_WORD+1:2];
                        len_q   <= awlen;
                        burst_q <= awburst;
                        oor_q   <= aw_oor;
                        cnt     <= '0;
                        state   <= WR_DATA;
                    end else if (arvalid) begin
                        id_q    <= arid;
                        addr_q  <= araddr[AW_WORD+1:2];
                        len_q   <= arlen;
                        burst_q <= arburst;
                        oor_q   <= ar_oor;
                        cnt     <= '0;
                        state   <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    rd_first <= 1'b1;
                    state    <= RD_DATA;
                end
                RD_DATA: begin
                    if (rd_first) begin
                        rdata_q  <= beat_q;
                        rd_first <= 1'b0;
                    end
                    if (rready) begin
                        if (last_beat) begin
                            state <= IDLE;
                        end else begin
                            cnt    <= cnt + 4'd1;
                            addr_q <= addr_next;
                            state  <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        // The beat count, not wlast, ends the burst; disagreement is reported.
                        if ((wlast != last_beat) || oor_q) begin
                            err_q <= 1'b1;
                        end
                        cnt    <= cnt + 4'd1;
                        addr_q <= addr_next;
                        if (last_beat) begin
                            state <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        err_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_burst_slave.sv
// tb/tb_axi_sram_burst_slave.sv - randomized self-checking bench for axi_sram_burst_slave
module tb_axi_sram_burst_slave;
    import axi_sram_pkg::*;

    localparam int ID_W    = 8;
    localparam int AW_WORD = 14;
    localparam int DEPTH   = 1 << AW_WORD;

    logic              clk;
    logic              rst;
    logic [ID_W-1:0]   arid, awid, rid, bid;
    logic [31:0]       araddr, awaddr;
    logic [3:0]        arlen, awlen;
    logic [1:0]        arburst, awburst, rresp, bresp;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [31:0]       rdata, wdata, sram_d, sram_q;
    logic [3:0]        wstrb, sram_we;
    logic              sram_cs;
    logic [AW_WORD-1:0] sram_a;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wbuf_d  [16];
    logic [3:0]  wbuf_s  [16];

    int n_checks = 0;
    int n_errors = 0;
    int n_rhs    = 0;
    int n_cs     = 0;

    axi_sram_burst_slave #(.ID_W(ID_W), .AW_WORD(AW_WORD)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h10) return 32'hDEADBEEF;
        return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Word SRAM: synchronous read, per-byte write.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    end
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we == 4'h0) sram_q <= mem[sram_a];
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (rvalid && rready) n_rhs++;
        if (sram_cs) n_cs++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a, input int i, input logic [1:0] burst);
        return int'(((a >> 2) + ((burst == BURST_FIXED) ? 0 : i)) % DEPTH);
    endfunction

    function automatic bit is_oor(input logic [31:0] a);
`ifdef AXI_SRAM_RANGE_CHECK_EN
        return a >= (32'd1 << (AW_WORD + 2));
`else
        return a > 32'hFFFF_FFFF;
`endif
    endfunction

    // Entered and left in the low clock phase.
    task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input int mode);
        int budget;
        int beats;
        int rhs0;
        bit stalled;
        logic [31:0] held;
        logic [31:0] exp_d;
        rhs0 = n_rhs;
        arid = id; araddr = addr; arlen = 4'(len); arburst = burst; arvalid = 1'b1;
        rready = 1'b0;
        budget = 0;
        #1;
        while (!arready && budget < 50) begin @(negedge clk); #1; budget++; end
        check("ar_ready", 32'(arready), 1);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        check("r_lat1", 32'(rvalid), 0);
        @(negedge clk);
        #1;
        check("r_lat2", 32'(rvalid), 1);
        beats = 0; stalled = 0; held = '0; budget = 0;
        while (beats <= len && budget < 200) begin
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? ~rready : 1'($urandom_range(0, 1));
            #1;
            if (rvalid) begin
                if (stalled) check("r_stable", rdata, held);
                if (rready) begin
                    exp_d = is_oor(addr) ? 32'h0 : ref_mem[word_of(addr, beats, burst)];
                    check("r_data", rdata, exp_d);
                    check("r_last", 32'(rlast), 32'(beats == len));
                    check("r_id", 32'(rid), 32'(id));
                    check("r_resp", 32'(rresp), is_oor(addr) ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
                    beats++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = rdata;
                end
            end
            @(negedge clk);
            budget++;
        end
        rready = 1'b0;
        check("r_beats", 32'(beats), 32'(len + 1));
        check("r_handshakes", 32'(n_rhs - rhs0), 32'(len + 1));
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                               input logic [1:0] burst, input int wl_beat, input int bdelay,
                               input int abort_after);
        int budget;
        int w;
        bit err;
        awid = id; awaddr = addr; awlen = 4'(len); awburst = burst; awvalid = 1'b1;
        budget = 0;
        #1;
        while (!awready && budget < 50) begin @(negedge clk); #1; budget++; end
        check("aw_ready", 32'(awready), 1);
        if (arvalid) check("ar_held_off", 32'(arready), 0);
        @(negedge clk);
        awvalid = 1'b0;
        err = is_oor(addr) || (wl_beat != len);
        for (int beat = 0; beat <= len; beat++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            wvalid = 1'b1; wdata = wbuf_d[beat]; wstrb = wbuf_s[beat]; wlast = (beat == wl_beat);
            budget = 0;
            #1;
            while (!wready && budget < 50) begin @(negedge clk); #1; budget++; end
            check("w_ready", 32'(wready), 1);
            if (!is_oor(addr)) begin
                w = word_of(addr, beat, burst);
                for (int b = 0; b < 4; b++)
                    if (wbuf_s[beat][b]) ref_mem[w][8*b +: 8] = wbuf_d[beat][8*b +: 8];
            end
            @(negedge clk);
            wvalid = 1'b0; wlast = 1'b0;
            if (beat == abort_after) return;
        end
        #1;
        check("b_latency", 32'(bvalid), 1);
        check("b_id", 32'(bid), 32'(id));
        check("b_resp", 32'(bresp), err ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
        repeat (bdelay) @(negedge clk);
        bready = 1'b1;
        #1;
        check("b_held", 32'(bvalid), 1);
        @(negedge clk);
        bready = 1'b0;
        #1;
        check("b_done", 32'(bvalid), 0);
    endtask

    initial begin
        int cs0;
        int len;
        logic [1:0] burst;
        logic [31:0] addr;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        rst = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_arready", 32'(arready), 0);
        check("rst_awready", 32'(awready), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rdata", rdata, 0);
        check("rst_ids", 32'({rid, bid}), 0);
        check("rst_resps", 32'({rresp, bresp}), 0);
        check("rst_sram", 32'({sram_cs, sram_we}), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        read_burst(8'h21, 32'h40, 0, BURST_INCR, 0);

        for (int i = 0; i < 4; i++) begin wbuf_d[i] = 32'(i + 1); wbuf_s[i] = 4'hF; end
        write_burst(8'h05, 32'h100, 3, BURST_INCR, 3, 0, -1);
        check("wr_word40", ref_mem[32'h40], 1);
        check("wr_word43", ref_mem[32'h43], 4);
        read_burst(8'h06, 32'h100, 3, BURST_INCR, 0);
        read_burst(8'h07, 32'h100, 3, BURST_INCR, 1);

        // AR and AW together: write first, read of the same word afterwards.
        arid = 8'h33; araddr = 32'h300; arlen = 4'd0; arburst = BURST_INCR; arvalid = 1'b1;
        wbuf_d[0] = 32'h0000AB00; wbuf_s[0] = 4'h2;
        write_burst(8'h32, 32'h300, 0, BURST_INCR, 0, 1, -1);
        read_burst(8'h33, 32'h300, 0, BURST_INCR, 0);

        for (int i = 0; i < 4; i++) begin wbuf_d[i] = $urandom(); wbuf_s[i] = 4'hF; end
        write_burst(8'h40, 32'h400, 3, BURST_INCR, 2, 0, -1);
        read_burst(8'h41, 32'h400, 3, BURST_INCR, 2);

        for (int i = 0; i < 4; i++) begin wbuf_d[i] = $urandom(); wbuf_s[i] = 4'hF; end
        write_burst(8'h50, 32'hFFF8, 3, BURST_INCR, 3, 0, -1);
        read_burst(8'h51, 32'hFFF8, 3, BURST_WRAP, 0);
        write_burst(8'h52, 32'h500, 2, BURST_FIXED, 2, 0, -1);
        read_burst(8'h53, 32'h500, 1, BURST_INCR, 0);

`ifdef AXI_SRAM_RANGE_CHECK_EN
        cs0 = n_cs;
        read_burst(8'h60, 32'h10000, 0, BURST_INCR, 0);
        check("oor_no_cs", 32'(n_cs - cs0), 0);
`endif

        // Reset in the middle of a write burst.
        wbuf_d[0] = 32'h55AA55AA; wbuf_s[0] = 4'hF;
        write_burst(8'h44, 32'h200, 3, BURST_INCR, 3, 0, 0);
        wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; rst = 1'b0;
        #1;
        check("mid_rst_wready", 32'(wready), 0);
        check("mid_rst_bvalid", 32'(bvalid), 0);
        check("mid_rst_sram", 32'({sram_cs, sram_we}), 0);
        repeat (2) @(negedge clk);
        wvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        read_burst(8'h45, 32'h200, 1, BURST_INCR, 0);

        for (int t = 0; t < 40; t++) begin
            len   = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 2));
            addr  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wbuf_d[i] = $urandom();
                    wbuf_s[i] = 4'($urandom_range(0, 15));
                end
                write_burst(8'($urandom()), addr, len, burst,
                            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : len,
                            $urandom_range(0, 2), -1);
            end else begin
                read_burst(8'($urandom()), addr, len, burst, $urandom_range(0, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
